sc_regtimer_down: RTL

SC_REGTIMER_DOWN -- requirements
Module: sc_regtimer_down

---
 rtl/sc_regtimer_pkg.sv | 47 ++++
 rtl/sc_regtimer_down_if.sv | 35 +++
 rtl/sc_regtimer_datapath.sv | 43 ++++
 rtl/sc_regtimer_down.sv | 91 +++++++++
 4 files changed

// File: rtl/sc_regtimer_pkg.sv
// Shared constants for the down-counting register timer: state encoding,
// datapath operations and the per-cycle event decoded by the control FSM.
package sc_regtimer_pkg;

   localparam int SC_REGTIMER_DEF_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } tmr_state_t;

   typedef enum logic [2:0] {
      OP_HOLD,
      OP_CLEAR,
      OP_LOAD,
      OP_RELOAD,
      OP_DEC
   } dp_op_t;

   // One winner per cycle after the clear > load > start > pause > tick priority
   typedef enum logic [3:0] {
      EV_NONE,
      EV_CLEAR,
      EV_LOAD,
      EV_START_CNT,
      EV_START_RLD,
      EV_START_EMPTY,
      EV_PAUSE,
      EV_RESUME,
      EV_DEC,
      EV_EXPIRE,
      EV_REARM
   } tmr_ev_t;

   function automatic dp_op_t ev_to_op(tmr_ev_t ev);
      case (ev)
         EV_CLEAR, EV_START_EMPTY, EV_EXPIRE: return OP_CLEAR;
         EV_LOAD:                             return OP_LOAD;
         EV_START_RLD, EV_REARM:              return OP_RELOAD;
         EV_DEC:                              return OP_DEC;
         default:                             return OP_HOLD;
      endcase
   endfunction

endpackage

// File: rtl/sc_regtimer_down_if.sv
// Control/status bundle of the register timer; slave side is the timer itself.
interface sc_regtimer_down_if
   import sc_regtimer_pkg::*;
#(
   parameter int RegTIMER_DATAWIDTH = SC_REGTIMER_DEF_W
);
   logic                          SC_RegTIMER_clear_InHigh;
   logic                          SC_RegTIMER_load_InHigh;
   logic [RegTIMER_DATAWIDTH-1:0] SC_RegTIMER_data_InBUS;
   logic                          SC_RegTIMER_start_InHigh;
   logic                          SC_RegTIMER_pause_InHigh;
   logic                          SC_RegTIMER_tick_InHigh;
   logic                          SC_RegTIMER_reload_InHigh;
   logic [RegTIMER_DATAWIDTH-1:0] SC_RegTIMER_count_OutBUS;
   logic                          SC_RegTIMER_busy_OutHigh;
   logic                          SC_RegTIMER_done_OutHigh;
   logic                          SC_RegTIMER_zero_OutHigh;

   modport master (
      output SC_RegTIMER_clear_InHigh, SC_RegTIMER_load_InHigh, SC_RegTIMER_data_InBUS,
             SC_RegTIMER_start_InHigh, SC_RegTIMER_pause_InHigh, SC_RegTIMER_tick_InHigh,
             SC_RegTIMER_reload_InHigh,
      input  SC_RegTIMER_count_OutBUS, SC_RegTIMER_busy_OutHigh, SC_RegTIMER_done_OutHigh,
             SC_RegTIMER_zero_OutHigh
   );

   modport slave (
      input  SC_RegTIMER_clear_InHigh, SC_RegTIMER_load_InHigh, SC_RegTIMER_data_InBUS,
             SC_RegTIMER_start_InHigh, SC_RegTIMER_pause_InHigh, SC_RegTIMER_tick_InHigh,
             SC_RegTIMER_reload_InHigh,
      output SC_RegTIMER_count_OutBUS, SC_RegTIMER_busy_OutHigh, SC_RegTIMER_done_OutHigh,
             SC_RegTIMER_zero_OutHigh
   );

endinterface

// File: rtl/sc_regtimer_datapath.sv
// Count and reload registers with the ==0 / ==1 detectors the control FSM steers on.
module sc_regtimer_datapath
   import sc_regtimer_pkg::*;
#(
   parameter int W = SC_REGTIMER_DEF_W
) (
   input  logic         SC_RegGENERAL_CLOCK_50,
   input  logic         SC_RegGENERAL_RESET_InHigh,
   input  dp_op_t       i_op,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_count,
   output logic         o_cnt_eq0,
   output logic         o_cnt_eq1,
   output logic         o_rld_eq0
);
   logic [W-1:0] r_count;
   logic [W-1:0] r_reload;

   always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
      if (SC_RegGENERAL_RESET_InHigh) begin
         r_count  <= '0;
         r_reload <= '0;
      end else begin
         case (i_op)
            OP_CLEAR:  r_count <= '0;
            OP_LOAD: begin
               r_count  <= i_data;
               r_reload <= i_data;
            end
            OP_RELOAD: r_count <= r_reload;
            // saturate at zero even if a decrement is ever requested there
            OP_DEC:    if (r_count != '0) r_count <= r_count - W'(1);
            default: ;
         endcase
      end
   end

   assign o_count   = r_count;
   assign o_cnt_eq0 = (r_count == '0);
   assign o_cnt_eq1 = (r_count == W'(1));
   assign o_rld_eq0 = (r_reload == '0);

endmodule

// File: rtl/sc_regtimer_down.sv
// Down-counting register timer: IDLE/RUN/PAUSE/DONE control with pause, auto-reload
// and a one-cycle done pulse aligned with the first post-expiry count.
module sc_regtimer_down
   import sc_regtimer_pkg::*;
#(
   parameter int RegTIMER_DATAWIDTH = SC_REGTIMER_DEF_W
) (
   input  logic              SC_RegGENERAL_CLOCK_50,
   input  logic              SC_RegGENERAL_RESET_InHigh,
   sc_regtimer_down_if.slave io_tmr
);
   localparam int W = RegTIMER_DATAWIDTH;

   tmr_state_t   r_state;
   logic         r_done;
   tmr_ev_t      w_ev;
   logic [W-1:0] w_count;
   logic         w_cnt_eq0;
   logic         w_cnt_eq1;
   logic         w_rld_eq0;
   logic         w_run;
   logic         w_pause;

   assign w_run   = (r_state == ST_RUN);
   assign w_pause = (r_state == ST_PAUSE);

   always_comb begin
      w_ev = EV_NONE;
      if (io_tmr.SC_RegTIMER_clear_InHigh)
         w_ev = EV_CLEAR;
      else if (io_tmr.SC_RegTIMER_load_InHigh)
         w_ev = EV_LOAD;
      else if (io_tmr.SC_RegTIMER_start_InHigh && (r_state == ST_IDLE || r_state == ST_DONE)) begin
         // IDLE restarts from the loaded count, DONE restarts from the reload register
         if (r_state == ST_IDLE)
            w_ev = w_cnt_eq0 ? EV_START_EMPTY : EV_START_CNT;
         else
            w_ev = w_rld_eq0 ? EV_START_EMPTY : EV_START_RLD;
      end
      else if (w_run && io_tmr.SC_RegTIMER_pause_InHigh)
         w_ev = EV_PAUSE;
      else if (w_pause)
         w_ev = io_tmr.SC_RegTIMER_pause_InHigh ? EV_NONE : EV_RESUME;
      else if (w_run && io_tmr.SC_RegTIMER_tick_InHigh) begin
         if (w_cnt_eq1)
            w_ev = (io_tmr.SC_RegTIMER_reload_InHigh && !w_rld_eq0) ? EV_REARM : EV_EXPIRE;
         else if (!w_cnt_eq0)
            w_ev = EV_DEC;
      end
   end

   always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
      if (SC_RegGENERAL_RESET_InHigh) begin
         r_state <= ST_IDLE;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (w_ev)
            EV_CLEAR, EV_LOAD:                     r_state <= ST_IDLE;
            EV_START_CNT, EV_START_RLD, EV_RESUME: r_state <= ST_RUN;
            EV_PAUSE:                              r_state <= ST_PAUSE;
            EV_REARM: begin
               r_state <= ST_RUN;
               r_done  <= 1'b1;
            end
            EV_START_EMPTY, EV_EXPIRE: begin
               r_state <= ST_DONE;
               r_done  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   sc_regtimer_datapath #(.W(W)) u_dp (
      .SC_RegGENERAL_CLOCK_50     (SC_RegGENERAL_CLOCK_50),
      .SC_RegGENERAL_RESET_InHigh (SC_RegGENERAL_RESET_InHigh),
      .i_op                       (ev_to_op(w_ev)),
      .i_data                     (io_tmr.SC_RegTIMER_data_InBUS),
      .o_count                    (w_count),
      .o_cnt_eq0                  (w_cnt_eq0),
      .o_cnt_eq1                  (w_cnt_eq1),
      .o_rld_eq0                  (w_rld_eq0)
   );

   assign io_tmr.SC_RegTIMER_count_OutBUS = w_count;
   assign io_tmr.SC_RegTIMER_busy_OutHigh = w_run | w_pause;
   assign io_tmr.SC_RegTIMER_done_OutHigh = r_done;
   assign io_tmr.SC_RegTIMER_zero_OutHigh = w_cnt_eq0;

endmodule
